// File: rtl/fp8_align_stage.sv
// Two-stage E4M3 operand alignment: order by magnitude, then right-shift the smaller significand with sticky.
// Optional NaN flagging of 0x7F/0xFF codes is enabled by defining FP8_ALIGN_NAN_EN.
module fp8_align_stage #(
  parameter  int EXP_W = 4,
  parameter  int MAN_W = 3,
  localparam int SIG_W = MAN_W + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       out_exp,
  output logic [SIG_W-1:0]       out_big_m,
  output logic [SIG_W-1:0]       out_small_m,
  output logic                   out_sign_big,
  output logic                   out_sign_small,
  output logic                   out_eff_sub,
  output logic                   out_nan
);

  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

  // Right shift with every discarded bit folded into the LSB; large shifts collapse to pure sticky.
  function automatic logic [SIG_W-1:0] align_small(input logic hid, input logic [MAN_W-1:0] man,
                                                   input logic [EXP_W-1:0] diff);
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] mask;
    logic [SIG_W-1:0] shifted;
    sig = {hid, man, 3'b000};
    if (int'(diff) >= SIG_W) begin
      return {{(SIG_W-1){1'b0}}, |{hid, man}};
    end
    mask    = (SIG_W'(1) << diff) - SIG_W'(1);
    shifted = sig >> diff;
    shifted[0] = shifted[0] | (|(sig & mask));
    return shifted;
  endfunction

  logic                   sign_a, sign_b;
  logic [EXP_W-1:0]       exp_a, exp_b, eff_a, eff_b;
  logic [MAN_W-1:0]       man_a, man_b;
  logic                   hid_a, hid_b, a_big;
  logic                   s2_free;

  logic                   vld_p1;
  logic [EXP_W-1:0]       exp_big_p1, diff_p1;
  logic                   hid_big_p1, hid_small_p1;
  logic [MAN_W-1:0]       man_big_p1, man_small_p1;
  logic                   sign_big_p1, sign_small_p1, eff_sub_p1;

  logic                   vld_p2;
  logic [EXP_W-1:0]       exp_p2;
  logic [SIG_W-1:0]       big_m_p2, small_m_p2;
  logic                   sign_big_p2, sign_small_p2, eff_sub_p2;

  assign sign_a = in_a[EXP_W+MAN_W];
  assign sign_b = in_b[EXP_W+MAN_W];
  assign exp_a  = in_a[EXP_W+MAN_W-1 -: EXP_W];
  assign exp_b  = in_b[EXP_W+MAN_W-1 -: EXP_W];
  assign man_a  = in_a[MAN_W-1:0];
  assign man_b  = in_b[MAN_W-1:0];
  assign hid_a  = |exp_a;
  assign hid_b  = |exp_b;
  assign eff_a  = eff_exp(exp_a);
  assign eff_b  = eff_exp(exp_b);
  // A wins ties so equal magnitudes never swap.
  assign a_big  = {eff_a, hid_a, man_a} >= {eff_b, hid_b, man_b};

  assign s2_free  = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_free;

  // Stage 1: magnitude ordering and exponent difference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      exp_big_p1    <= '0;
      diff_p1       <= '0;
      hid_big_p1    <= 1'b0;
      hid_small_p1  <= 1'b0;
      man_big_p1    <= '0;
      man_small_p1  <= '0;
      sign_big_p1   <= 1'b0;
      sign_small_p1 <= 1'b0;
      eff_sub_p1    <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (in_valid && in_ready) begin
        eff_sub_p1 <= sign_a ^ sign_b;
        if (a_big) begin
          exp_big_p1    <= eff_a;
          diff_p1       <= eff_a - eff_b;
          hid_big_p1    <= hid_a;
          man_big_p1    <= man_a;
          sign_big_p1   <= sign_a;
          hid_small_p1  <= hid_b;
          man_small_p1  <= man_b;
          sign_small_p1 <= sign_b;
        end else begin
          exp_big_p1    <= eff_b;
          diff_p1       <= eff_b - eff_a;
          hid_big_p1    <= hid_b;
          man_big_p1    <= man_b;
          sign_big_p1   <= sign_b;
          hid_small_p1  <= hid_a;
          man_small_p1  <= man_a;
          sign_small_p1 <= sign_a;
        end
      end
    end
  end

  // Stage 2: significand alignment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2        <= 1'b0;
      exp_p2        <= '0;
      big_m_p2      <= '0;
      small_m_p2    <= '0;
      sign_big_p2   <= 1'b0;
      sign_small_p2 <= 1'b0;
      eff_sub_p2    <= 1'b0;
    end else begin
      if (s2_free) vld_p2 <= vld_p1;
      if (vld_p1 && s2_free) begin
        exp_p2        <= exp_big_p1;
        big_m_p2      <= {hid_big_p1, man_big_p1, 3'b000};
        small_m_p2    <= align_small(hid_small_p1, man_small_p1, diff_p1);
        sign_big_p2   <= sign_big_p1;
        sign_small_p2 <= sign_small_p1;
        eff_sub_p2    <= eff_sub_p1;
      end
    end
  end

`ifdef FP8_ALIGN_NAN_EN
  logic nan_in, nan_p1, nan_p2;
  // exp all-ones with man all-ones means every non-sign bit is set
  assign nan_in = (&in_a[EXP_W+MAN_W-1:0]) || (&in_b[EXP_W+MAN_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_p1 <= 1'b0;
      nan_p2 <= 1'b0;
    end else begin
      if (in_valid && in_ready) nan_p1 <= nan_in;
      if (vld_p1 && s2_free)    nan_p2 <= nan_p1;
    end
  end
  assign out_nan = nan_p2;
`else
  assign out_nan = 1'b0;
`endif

  assign out_valid      = vld_p2;
  assign out_exp        = exp_p2;
  assign out_big_m      = big_m_p2;
  assign out_small_m    = small_m_p2;
  assign out_sign_big   = sign_big_p2;
  assign out_sign_small = sign_small_p2;
  assign out_eff_sub    = eff_sub_p2;

endmodule

// File: tb/tb_fp8_align_stage.sv
// Randomized and directed bench for fp8_align_stage against an integer-arithmetic reference model.
module tb_fp8_align_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] out_exp;
  logic [6:0] out_big_m, out_small_m;
  logic       out_sign_big, out_sign_small, out_eff_sub, out_nan;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [21:0] exp_q[$];
  logic        held = 1'b0;
  logic [21:0] hold_v;

  fp8_align_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_big_m(out_big_m), .out_small_m(out_small_m),
    .out_sign_big(out_sign_big), .out_sign_small(out_sign_small),
    .out_eff_sub(out_eff_sub), .out_nan(out_nan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [21:0] observed();
    return {out_exp, out_big_m, out_small_m, out_sign_big, out_sign_small, out_eff_sub, out_nan};
  endfunction

  // Reference: values as real-number magnitudes on an integer grid of 1/8 ulp.
  function automatic logic [21:0] model(input logic [7:0] a, input logic [7:0] b);
    int ea, eb, fa, fb, ka, kb, big_e, diff, big_f, small_f, small_v, sb, ss, nan;
    ea = (a >> 3) & 15;  eb = (b >> 3) & 15;
    fa = ((ea != 0) ? 8 : 0) + (a & 7);
    fb = ((eb != 0) ? 8 : 0) + (b & 7);
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    ka = ea * 16 + fa;
    kb = eb * 16 + fb;
    if (ka >= kb) begin
      big_e = ea; diff = ea - eb; big_f = fa; small_f = fb; sb = a[7]; ss = b[7];
    end else begin
      big_e = eb; diff = eb - ea; big_f = fb; small_f = fa; sb = b[7]; ss = a[7];
    end
    if (diff >= 7) small_v = (small_f != 0) ? 1 : 0;
    else begin
      small_v = (small_f * 8) / (2 ** diff);
      if (((small_f * 8) % (2 ** diff)) != 0) small_v = small_v | 1;
    end
`ifdef FP8_ALIGN_NAN_EN
    nan = (((a & 8'h7F) == 8'h7F) || ((b & 8'h7F) == 8'h7F)) ? 1 : 0;
`else
    nan = 0;
`endif
    return {4'(big_e), 7'(big_f * 8), 7'(small_v), 1'(sb), 1'(ss), 1'(a[7] ^ b[7]), 1'(nan)};
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy, output logic acc);
    in_valid = v; in_a = a; in_b = b; out_ready = ordy;
    #1;
    if (out_valid && held) check("hold_stable", observed(), hold_v);
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else check("stream", observed(), exp_q.pop_front());
    end
    held   = out_valid && !out_ready;
    hold_v = observed();
    acc    = v && in_ready;
    if (acc) exp_q.push_back(model(a, b));
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    repeat (4) step(1'b0, 8'h00, 8'h00, 1'b1, acc);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [21:0] want);
    logic acc;
    step(1'b1, a, b, 1'b1, acc);
    check({tag, "_acc"}, acc, 1);
    step(1'b0, 8'h00, 8'h00, 1'b1, acc);
    check({tag, "_vld"}, out_valid, 1);
    check(tag, observed(), want);
  endtask

  initial begin
    logic acc;
    logic [7:0] pa[3], pb[3];
    int k, p0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fields", observed(), 0);
    @(negedge clk);

    directed("basic",  8'h40, 8'h38, {4'd8,  7'h40, 7'h20, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("swap",   8'h38, 8'hC0, {4'd8,  7'h40, 7'h20, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("sticky", 8'h60, 8'h47, {4'd12, 7'h40, 7'h07, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("subn",   8'h70, 8'h01, {4'd14, 7'h40, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("tie",    8'h45, 8'hC5, {4'd8,  7'h68, 7'h68, 1'b0, 1'b1, 1'b1, 1'b0});
`ifdef FP8_ALIGN_NAN_EN
    directed("nan",    8'h7F, 8'h38, {4'd15, 7'h78, 7'h01, 1'b0, 1'b0, 1'b0, 1'b1});
`else
    directed("nan",    8'h7F, 8'h38, {4'd15, 7'h78, 7'h01, 1'b0, 1'b0, 1'b0, 1'b0});
`endif
    drain();

    // Backpressure: only two pairs fit while the output is stalled.
    for (int i = 0; i < 3; i++) begin
      pa[i] = 8'($urandom); pb[i] = 8'($urandom);
    end
    k = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pa[k], pb[k], 1'b0, acc);
      if (acc) k++;
    end
    check("bp_accepted", k, 2);
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    @(negedge clk);
    p0 = pops;
    step(1'b1, pa[2], pb[2], 1'b1, acc);
    check("bp_push_pop", acc, 1);
    step(1'b0, 8'h00, 8'h00, 1'b1, acc);
    step(1'b0, 8'h00, 8'h00, 1'b1, acc);
    check("bp_drain_rate", pops - p0, 3);
    drain();

    // Asynchronous reset with both stages occupied.
    step(1'b1, 8'h55, 8'h22, 1'b0, acc);
    step(1'b1, 8'h66, 8'h11, 1'b0, acc);
    check("full_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_fields", observed(), 0);
    exp_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h40, 8'h38, 1'b1, acc);
    check("post_rst_acc", acc, 1);
    step(1'b0, 8'h00, 8'h00, 1'b1, acc);
    check("post_rst_vld", out_valid, 1);
    check("post_rst_exp", out_exp, 8);
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0), acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
